// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares the single DRAM data port between the CPU data path (master 0)
//   and a secondary bus master (master 1). It issues at most one access per
//   cycle and drives the DRAM address, write enable and write data from the
//   winner. Read data is registered back to the winning master. A master can
//   hold the port for a short burst by asserting lock.
//
//   Build option DRAM_ARB_RR_EN:
//     defined   - round-robin arbitration in IDLE with a 1-bit last-grant
//                 pointer. No starvation counter is built.
//     undefined - fixed priority (master 0 wins contention). A starvation
//                 counter forces master 1 through after STARVE_MAX
//                 consecutive losing cycles.
//
//   Ports:
//     cpu_clk, cpu_rst           clock, synchronous active-high reset
//     mX_req/we/lock/addr/wdata  master X request (held until granted)
//     mX_gnt                     combinational grant, access issued this cycle
//     mX_rvalid/rdata            registered read return, one cycle after grant
//     dram_a/we/d                DRAM word address, write enable, write data
//     dram_spo                   DRAM asynchronous read data
//
//   state | meaning
//   IDLE  | arbitrate between requesting masters
//   OWN0  | master 0 holds a locked burst, only master 0 can be granted
//   OWN1  | master 1 holds a locked burst, only master 1 can be granted
module dram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dram_a,
  output logic              dram_we,
  output logic [DATA_W-1:0] dram_d,
  input  logic [DATA_W-1:0] dram_spo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              gnt0, gnt1;
  logic              pick1;
  logic              m0_rvalid_q, m1_rvalid_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  // Address byte-offset bits and bits above the DRAM range are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr, m1_addr};

`ifdef DRAM_ARB_RR_EN
  localparam int UNUSED_STARVE_MAX = STARVE_MAX;

  // Last granted master; resets to 1 so master 0 wins the first contention.
  logic ptr_q, ptr_d;

  assign pick1 = m1_req & (~m0_req | ~ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (gnt0) begin
      ptr_d = 1'b0;
    end else if (gnt1) begin
      ptr_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  // The counter only takes effect in IDLE; a locked owner is never preempted.
  assign pick1 = m1_req & (~m0_req | (starve_q == CNT_MAX));

  always_comb begin
    starve_d = '0;
    if (m1_req && !gnt1) begin
      starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!cpu_rst) begin
      case (state_q)
        ST_OWN0: gnt0 = m0_req;
        ST_OWN1: gnt1 = m1_req;
        default: begin
          gnt1 = pick1;
          gnt0 = m0_req & ~pick1;
        end
      endcase
    end
  end

  // In an OWN state the owner is granted whenever it requests, so the burst
  // ends either on a request without lock or when the owner goes quiet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OWN0: if (!m0_req || !m0_lock) state_d = ST_IDLE;
      ST_OWN1: if (!m1_req || !m1_lock) state_d = ST_IDLE;
      default: begin
        if (gnt0 && m0_lock) begin
          state_d = ST_OWN0;
        end else if (gnt1 && m1_lock) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // With no grant the DRAM port shows master 0's address and data.
  assign dram_a  = gnt1 ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
  assign dram_d  = gnt1 ? m1_wdata : m0_wdata;
  assign dram_we = (gnt0 & m0_we) | (gnt1 & m1_we);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= gnt0 & ~m0_we;
      m1_rvalid_q <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) m0_rdata_q <= dram_spo;
      if (gnt1 && !m1_we) m1_rdata_q <= dram_spo;
    end
  end

  // A read return already in flight is suppressed while reset is asserted.
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q & ~cpu_rst;
  assign m1_rvalid = m1_rvalid_q & ~cpu_rst;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
